// File: rtl/bcrypt_wrapper_pkg.sv
// rtl/bcrypt_wrapper_pkg.sv - shared constants and helpers for the bcrypt proxy wrapper
package bcrypt_wrapper_pkg;

    localparam logic [1:0] CTRL_DATA        = 2'b00;
    localparam logic [1:0] CTRL_INIT_START  = 2'b01;
    localparam logic [1:0] CTRL_CRYPT_START = 2'b10;
    localparam logic [1:0] CTRL_END         = 2'b11;

    localparam int CONF_NUM_CORES_LSB = 0;
    localparam int CONF_NUM_CORES_W   = 8;
    localparam int CONF_REGS_LSB      = 8;
    localparam int CONF_REGS_W        = 4;
    localparam int CONF_CORES_ND_LSB  = 12;
    localparam int CONF_IS_DUMMY_BIT  = 31;

    localparam int MAX_REGS = 4;
    localparam int MASK_W   = 4;

    // Readies stay hidden for the full write-to-proxy plus ready-return round trip.
    function automatic logic [MASK_W-1:0] mask_load(input int regs);
        return MASK_W'(2 * regs + 1);
    endfunction

endpackage

// File: rtl/bcrypt_proxy.sv
// rtl/bcrypt_proxy.sv - behavioural stand-in proxy with one-cycle registered status
module bcrypt_proxy
    import bcrypt_wrapper_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter bit DUMMY     = 1'b0,
    parameter int DIN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 mode_cmp,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic [1:0]           ctrl,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic                 init_ready,
    output logic                 crypt_ready,
    output logic                 empty,
    output logic                 dout
);

    localparam logic ACTIVE = (NUM_CORES != 0) || DUMMY;

    // Status is a pure function of last cycle's inputs, so it needs no reset of its own.
    always_ff @(posedge CLK) begin
        init_ready  <= ACTIVE && !(wr_en && ctrl == CTRL_END);
        crypt_ready <= ACTIVE && !(wr_en && ctrl == CTRL_CRYPT_START);
        empty       <= !(wr_en && ctrl == CTRL_DATA);
        dout        <= rd_en ? ((^din) ^ mode_cmp) : (wr_en & din[0]);
    end

endmodule

// File: rtl/bcrypt_wrapper_lane.sv
// rtl/bcrypt_wrapper_lane.sv - per-proxy enable taps, return pipeline and ready mask
module bcrypt_wrapper_lane
    import bcrypt_wrapper_pkg::*;
#(
    parameter int REGS      = 1,
    parameter int NUM_CORES = 1,
    parameter bit DUMMY     = 1'b0,
    parameter int DIN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 mode_cmp,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 end_write,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic [1:0]           ctrl,
    output logic                 init_ready,
    output logic                 crypt_ready,
    output logic                 empty,
    output logic                 dout
);

    if (REGS < 1 || REGS > MAX_REGS) begin : g_bad_regs
        $error("bcrypt_wrapper_lane: regs must be 1..4");
    end

    logic [REGS-1:0]   wr_sr, rd_sr;
    logic [REGS-1:0]   ir_sr, cr_sr, em_sr, do_sr;
    logic [MASK_W-1:0] mask_cnt;
    logic              p_init_ready, p_crypt_ready, p_empty, p_dout;

    // Enable taps toward the proxy: REGS-deep shift of this proxy's wr_en/rd_en bit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_sr <= '0;
            rd_sr <= '0;
        end else begin
            wr_sr[0] <= wr_en;
            rd_sr[0] <= rd_en;
            for (int k = 1; k < REGS; k++) begin
                wr_sr[k] <= wr_sr[k-1];
                rd_sr[k] <= rd_sr[k-1];
            end
        end
    end

    // Return path: REGS flops per status bit; empty idles high so the arbiter never pops garbage.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ir_sr <= '0;
            cr_sr <= '0;
            em_sr <= '1;
            do_sr <= '0;
        end else begin
            ir_sr[0] <= p_init_ready;
            cr_sr[0] <= p_crypt_ready;
            em_sr[0] <= p_empty;
            do_sr[0] <= p_dout;
            for (int k = 1; k < REGS; k++) begin
                ir_sr[k] <= ir_sr[k-1];
                cr_sr[k] <= cr_sr[k-1];
                em_sr[k] <= em_sr[k-1];
                do_sr[k] <= do_sr[k-1];
            end
        end
    end

    // Mask counter: reload on every end-write, otherwise count down to zero.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mask_cnt <= '0;
        end else if (end_write) begin
            mask_cnt <= mask_load(REGS);
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - {{(MASK_W-1){1'b0}}, 1'b1};
        end
    end

    assign init_ready  = ir_sr[REGS-1] && (mask_cnt == '0);
    assign crypt_ready = cr_sr[REGS-1] && (mask_cnt == '0);
    assign empty       = em_sr[REGS-1];
    assign dout        = do_sr[REGS-1];

    bcrypt_proxy #(
        .NUM_CORES (NUM_CORES),
        .DUMMY     (DUMMY),
        .DIN_WIDTH (DIN_WIDTH)
    ) u_proxy (
        .CLK         (CLK),
        .mode_cmp    (mode_cmp),
        .din         (din),
        .ctrl        (ctrl),
        .wr_en       (wr_sr[REGS-1]),
        .rd_en       (rd_sr[REGS-1]),
        .init_ready  (p_init_ready),
        .crypt_ready (p_crypt_ready),
        .empty       (p_empty),
        .dout        (p_dout)
    );

endmodule

// File: rtl/bcrypt_wrapper_pipe.sv
// rtl/bcrypt_wrapper_pipe.sv - pipelined multi-proxy bcrypt wrapper with ready masking
module bcrypt_wrapper_pipe
    import bcrypt_wrapper_pkg::*;
#(
    parameter int                        NUM_PROXIES = 2,
    parameter int                        DIN_WIDTH   = 8,
    parameter logic [32*NUM_PROXIES-1:0] PROXY_CONF  = {32'h0000_0201, 32'h0000_0101}
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   mode_cmp,
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic [1:0]             ctrl,
    input  logic [NUM_PROXIES-1:0] wr_en,
    input  logic [NUM_PROXIES-1:0] rd_en,
    output logic [NUM_PROXIES-1:0] init_ready,
    output logic [NUM_PROXIES-1:0] crypt_ready,
    output logic [NUM_PROXIES-1:0] empty,
    output logic [NUM_PROXIES-1:0] dout
);

    if (NUM_PROXIES < 1 || NUM_PROXIES > 32) begin : g_bad_count
        $error("bcrypt_wrapper_pipe: NUM_PROXIES must be 1..32");
    end

    logic [DIN_WIDTH-1:0] din_stage  [MAX_REGS];
    logic [1:0]           ctrl_stage [MAX_REGS];
    logic [MAX_REGS-2:0]  any_wr_r;

    // Shared data chain: each stage advances only behind a write, so every tap holds its byte.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            any_wr_r <= '0;
            for (int k = 0; k < MAX_REGS; k++) begin
                din_stage[k]  <= '0;
                ctrl_stage[k] <= '0;
            end
        end else begin
            any_wr_r[0] <= |wr_en;
            for (int k = 1; k < MAX_REGS - 1; k++) begin
                any_wr_r[k] <= any_wr_r[k-1];
            end
            if (|wr_en) begin
                din_stage[0]  <= din;
                ctrl_stage[0] <= ctrl;
            end
            for (int k = 1; k < MAX_REGS; k++) begin
                if (any_wr_r[k-1]) begin
                    din_stage[k]  <= din_stage[k-1];
                    ctrl_stage[k] <= ctrl_stage[k-1];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PROXIES; i++) begin : g_lane
        localparam int R   = int'(PROXY_CONF[32*i+CONF_REGS_LSB +: CONF_REGS_W]);
        localparam int TAP = (R >= 1 && R <= MAX_REGS) ? R - 1 : 0;

        bcrypt_wrapper_lane #(
            .REGS      (R),
            .NUM_CORES (int'(PROXY_CONF[32*i+CONF_NUM_CORES_LSB +: CONF_NUM_CORES_W])),
            .DUMMY     (PROXY_CONF[32*i+CONF_IS_DUMMY_BIT]),
            .DIN_WIDTH (DIN_WIDTH)
        ) u_lane (
            .CLK         (CLK),
            .RST_N       (RST_N),
            .mode_cmp    (mode_cmp),
            .wr_en       (wr_en[i]),
            .rd_en       (rd_en[i]),
            .end_write   (wr_en[i] && ctrl == CTRL_END),
            .din         (din_stage[TAP]),
            .ctrl        (ctrl_stage[TAP]),
            .init_ready  (init_ready[i]),
            .crypt_ready (crypt_ready[i]),
            .empty       (empty[i]),
            .dout        (dout[i])
        );
    end

endmodule

// File: tb/tb_bcrypt_wrapper_pipe.sv
// tb/tb_bcrypt_wrapper_pipe.sv - randomized self-checking bench for bcrypt_wrapper_pipe
module tb_bcrypt_wrapper_pipe;

    localparam int NP   = 4;
    localparam int MAXC = 2048;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          mode_cmp;
    logic [7:0]    din;
    logic [1:0]    ctrl;
    logic [NP-1:0] wr_en, rd_en;
    logic [NP-1:0] init_ready, crypt_ready, empty, dout;

    bcrypt_wrapper_pipe #(
        .NUM_PROXIES (NP),
        .DIN_WIDTH   (8),
        .PROXY_CONF  ({32'h0000_0401, 32'h8000_0301, 32'h0000_0201, 32'h0000_0101})
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .mode_cmp    (mode_cmp),
        .din         (din),
        .ctrl        (ctrl),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .init_ready  (init_ready),
        .crypt_ready (crypt_ready),
        .empty       (empty),
        .dout        (dout)
    );

    always #5 CLK = ~CLK;

    int regs_of [NP] = '{1, 2, 3, 4};

    logic          rst_h  [MAXC];
    logic [NP-1:0] wr_h   [MAXC];
    logic [NP-1:0] rd_h   [MAXC];
    logic [7:0]    din_h  [MAXC];
    logic [1:0]    ctrl_h [MAXC];
    logic          mode_h [MAXC];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reset asserted at any edge closing cycles a..b (before time zero counts as reset).
    function automatic bit rst_in(int a, int b);
        for (int c = a; c <= b; c++) begin
            if (c < 0 || !rst_h[c]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Proxy status bit (sel: 0 init, 1 crypt, 2 empty, 3 dout) during cycle p.
    function automatic logic proxy_out(int i, int sel, int p);
        int         q = p - 1;
        int         r = regs_of[i];
        logic       w = 1'b0;
        logic       rdx = 1'b0;
        logic [7:0] d = 8'h00;
        logic [1:0] c = 2'b00;
        if (!rst_in(q - r, q - 1)) begin
            w   = wr_h[q-r][i];
            rdx = rd_h[q-r][i];
        end
        for (int s = q - r; s >= 0; s--) begin
            if (|wr_h[s]) begin
                if (!rst_in(s, q - 1)) begin
                    d = din_h[s];
                    c = ctrl_h[s];
                end
                break;
            end
        end
        case (sel)
            0:       return !(w && c == 2'b11);
            1:       return !(w && c == 2'b10);
            2:       return !(w && c == 2'b00);
            default: return rdx ? ((^d) ^ mode_h[q]) : (w & d[0]);
        endcase
    endfunction

    // An end-write at s hides both readies during s+1 .. s+2r+1.
    function automatic bit masked(int i, int t);
        int r = regs_of[i];
        for (int s = t - 1; s >= t - 2 * r - 1; s--) begin
            if (s >= 0 && wr_h[s][i] && ctrl_h[s] == 2'b11) return !rst_in(s, t - 1);
        end
        return 1'b0;
    endfunction

    function automatic logic [NP-1:0] exp_out(int sel, int t);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) begin
            int r = regs_of[i];
            if (rst_in(t - r, t - 1)) begin
                v[i] = (sel == 2);
            end else begin
                logic b;
                b = proxy_out(i, sel, t - r);
                if (sel < 2 && masked(i, t)) b = 1'b0;
                v[i] = b;
            end
        end
        return v;
    endfunction

    always @(posedge CLK) begin
        rst_h[cyc]  = RST_N;
        wr_h[cyc]   = wr_en;
        rd_h[cyc]   = rd_en;
        din_h[cyc]  = din;
        ctrl_h[cyc] = ctrl;
        mode_h[cyc] = mode_cmp;
        cyc = cyc + 1;
    end

    always @(negedge CLK) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check("init_ready",  32'(init_ready),  32'(exp_out(0, cyc)));
            check("crypt_ready", 32'(crypt_ready), 32'(exp_out(1, cyc)));
            check("empty",       32'(empty),       32'(exp_out(2, cyc)));
            check("dout",        32'(dout),        32'(exp_out(3, cyc)));
        end
    end

    task automatic step(input logic rstn, input logic [NP-1:0] wr, input logic [NP-1:0] rd,
                        input logic [7:0] d, input logic [1:0] c, input logic m);
        RST_N    = rstn;
        wr_en    = wr;
        rd_en    = rd;
        din      = d;
        ctrl     = c;
        mode_cmp = m;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0, '0, 8'h00, 2'b00, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 8'h00, 2'b00, 1'b0);
        idle(6);
        step(1'b1, 4'b1000, '0, 8'hA5, 2'b00, 1'b0);
        idle(6);
        step(1'b1, 4'b0001, '0, 8'h11, 2'b00, 1'b0);
        step(1'b1, 4'b0010, '0, 8'h22, 2'b00, 1'b0);
        idle(5);
        step(1'b1, 4'b0010, '0, 8'h00, 2'b11, 1'b0);
        idle(8);
        step(1'b1, 4'b0001, '0, 8'h00, 2'b11, 1'b0);
        idle(1);
        step(1'b1, 4'b0001, '0, 8'h00, 2'b11, 1'b0);
        idle(6);
        step(1'b1, 4'b0100, '0, 8'h01, 2'b00, 1'b0);
        idle(4);
        step(1'b1, '0, 4'b0100, 8'h00, 2'b00, 1'b0);
        idle(6);
        step(1'b1, 4'b0001, '0, 8'h5A, 2'b10, 1'b0);
        step(1'b1, 4'b1000, '0, 8'h3C, 2'b11, 1'b1);
        idle(10);
        for (int n = 0; n < 1200; n++) begin
            logic [NP-1:0] wr;
            logic          rstn;
            wr   = ($urandom_range(0, 3) != 0) ? NP'(1 << $urandom_range(0, NP - 1)) : '0;
            rstn = ($urandom_range(0, 149) != 0);
            step(rstn, wr, NP'($urandom & $urandom), 8'($urandom), 2'($urandom), 1'($urandom));
        end
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcrypt_wrapper_pipe.md
# bcrypt_wrapper_pipe

Parametrised successor to the two-proxy bcrypt wrapper. It instantiates `NUM_PROXIES` `bcrypt_proxy` instances, each with its own register depth of 1..4 stages in both directions. It adds per-proxy ready masking so the arbiter cannot issue a second packet before the proxy's deasserted ready has travelled back through the pipeline. It sits between the bcrypt arbiter/`bcrypt_data` and the proxies.

## Interface
Parameters:
- `NUM_PROXIES`, default 2: proxy count, 1..32.
- `DIN_WIDTH`, default 8: data byte width toward proxies.
- `PROXY_CONF`, default two proxies (proxy 1 = 2 regs, proxy 0 = 1 reg, 1 core each): 32 bits per proxy, `{is_dummy[31], cores_not_dummy[30:12], regs[11:8], num_cores[7:0]}`.
  - `regs` must be 1..4.
  - Any other `regs` value is an elaboration error.

Ports:
- `CLK`  in  1: clock. Single clock domain.
- `RST_N`  in  1: synchronous reset, active-low.
- `mode_cmp`  in  1: passed unregistered to all proxies.
- `din`  in  `DIN_WIDTH`: data byte toward proxies.
- `ctrl`  in  2: packet control. 00 = data, 01 = init start, 10 = crypt start, 11 = end.
- `wr_en`  in  `NUM_PROXIES`: one-hot write select.
- `rd_en`  in  `NUM_PROXIES`: per-proxy serial read pop.
- `init_ready`  out  `NUM_PROXIES`: delayed proxy init_ready, masked.
- `crypt_ready`  out  `NUM_PROXIES`: delayed proxy crypt_ready, masked.
- `empty`  out  `NUM_PROXIES`: delayed proxy empty.
- `dout`  out  `NUM_PROXIES`: delayed proxy serial output bit.

## Operation
- **Forward data chain.** One shared chain of 4 stages for `din`/`ctrl`.
  - Stage 1 loads from the inputs when `|wr_en`.
  - Stage k loads from stage k-1 when `|wr_en_rk-1`.
  - Between loads, stages hold their value.
  - Proxy i taps stage `regs_i`.
- **Forward enable chains.** `wr_en` and `rd_en` each pass through a 4-deep per-bit shift chain. Proxy i takes tap `regs_i`.
- **Return path.** `init_ready`, `crypt_ready`, `empty` and `dout` from proxy i each pass through `regs_i` flops before reaching the outputs.
- **Mask counter.** Each proxy has a 4-bit down-counter `mask_cnt[i]`.
  - Loads `2*regs_i+1` when `wr_en[i]` is high with `ctrl==11`.
  - Otherwise decrements while nonzero, saturating at 0.
  - `init_ready[i]` = delayed init_ready AND (`mask_cnt[i]==0`). `crypt_ready[i]` follows the same rule.
  - A new end-write while the counter is nonzero reloads it. Counts do not accumulate.
- **Reads.** `rd_en` is never masked. The arbiter accounts for the `2*regs_i` read-to-empty round trip.
- **Dummy proxies.** A proxy with `is_dummy=1` is still instantiated with `DUMMY=1` and is handled identically.
- **Simultaneous `wr_en` bits.** Illegal (one-hot required). Behaviour is undefined beyond the shared data register capturing `din`.
- **Reset** (`RST_N` low at a clock edge):
  - All enable chains and mask counters go to 0.
  - All return-path ready and dout flops go to 0; all empty flops go to 1.
  - Data/ctrl stages reset to 0.
  - Reset mid-packet drops in-flight writes. Proxies are reset separately and are not driven by this block.

## Timing
- Output values during and immediately after reset:
  - `init_ready`, `crypt_ready` and `dout` are 0.
  - `empty` is all-ones.
  - These values hold until proxy values propagate `regs_i` cycles after reset release.
- Forward latency: `wr_en[i]`/`din` presented at cycle t reach proxy i at t+`regs_i`. `rd_en` has the same latency.
- Return latency: a proxy output change at cycle t is visible at t+`regs_i`.
- Masking window: an end-write at cycle t forces both readies of that proxy to 0 from t+1 through t+`2*regs_i`+1 inclusive. This covers the worst-case round trip for a proxy dropping ready one cycle after receiving end.
- Throughput: one write per cycle, back-to-back, across any proxies.

## Structure
- Package `bcrypt_wrapper_pkg` holds:
  - Ctrl codes `CTRL_DATA`, `CTRL_INIT_START`, `CTRL_CRYPT_START`, `CTRL_END`.
  - `PROXY_CONF` field offsets and `MAX_REGS=4`.
  - The mask-load function `2*regs+1`.
- Sub-module `bcrypt_wrapper_lane` contains per-proxy logic:
  - `rd_en`/`wr_en` taps.
  - Return-path flops with the `regs` parameter.
  - Mask counter and `bcrypt_proxy` instance.
- The top level holds the shared data chain and the generate loop.

## Test plan
- **Reset.** Assert `RST_N`=0 for 3 cycles with proxies idle. Expect `empty`=all-ones and `init_ready`=`crypt_ready`=`dout`=0 until cycle `regs_i` after release.
- **Forward latency.** `regs`=(1,4), write `din`=8'hA5, `ctrl`=00 to proxy 1 at cycle 10. Expect proxy 1 to see `wr_en` and `din`=A5 at cycle 14. Proxy 0 sees no `wr_en`.
- **Mask window.** `regs_0`=2, `init_ready` held high, end-write to proxy 0 at cycle 20. Expect `init_ready[0]`=0 in cycles 21..25 and 1 at cycle 26, given the proxy stays ready.
- **Mask reload.** `regs`=1, end-writes at cycles 5 and 7. Expect ready masked from cycle 6 through cycle 10.
- **Back-to-back writes across proxies.** Proxy 0 `regs`=1, proxy 1 `regs`=2. Write 8'h11 to proxy 0 at cycle 0, then 8'h22 to proxy 1 at cycle 1. Expect 11 at proxy 0 at cycle 1 and 22 at proxy 1 at cycle 3. No corruption.
- **Serial read.** Pulse `rd_en[1]` with `regs`=3 while the proxy holds `dout`=1. Expect `dout[1]`=1 three cycles after the proxy drives it. `empty` is unaffected by the block.
